// File: rtl/fp_wb_csr.sv
// ---------------------------------------------------------------------------
// fp_wb_csr
// Writeback and control-status stage for the single-precision adder datapath.
//   - Decodes the 3-bit frm register into one-hot rounding mode lines.
//   - Buffers rounded results plus exception flags in a 2-entry skid buffer
//     toward register-file writeback.
//   - Accumulates sticky exception flags (fflags) readable/writable via CSR.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      handshake from the rounding stage
//   in_result              rounded result {sign, exp, mant}
//   in_invalid..in_inexact exception flags for in_result
//   out_valid/out_ready    handshake toward writeback
//   out_result, out_flags  head-of-buffer result and flags {NV,DZ,OF,UF,NX}
//   csr_we, csr_addr,      CSR port: 0 = fflags, 1 = frm, 2 = fcsr,
//   csr_wdata, csr_rdata   3 = reserved (reads 0, writes ignored)
//   rne..rmm               one-hot rounding mode to the rounding stage
//   rm_illegal             frm holds a reserved encoding
// ---------------------------------------------------------------------------
module fp_wb_csr #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_result,
  input  logic         in_invalid,
  input  logic         in_dz,
  input  logic         in_overflow,
  input  logic         in_underflow,
  input  logic         in_inexact,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_result,
  output logic [4:0]   out_flags,
  input  logic         csr_we,
  input  logic [1:0]   csr_addr,
  input  logic [7:0]   csr_wdata,
  output logic [7:0]   csr_rdata,
  output logic         rne,
  output logic         rtz,
  output logic         rdn,
  output logic         rup,
  output logic         rmm,
  output logic         rm_illegal
);

  logic [2:0]   frm;
  logic [4:0]   fflags;
  logic [1:0]   count;
  logic         rd_ptr;
  logic         wr_ptr;
  logic [W-1:0] res_mem [2];
  logic [4:0]   flg_mem [2];

  logic         push;
  logic         pop;
  logic [4:0]   in_flags;
  logic         fflags_wr;
  logic [4:0]   fflags_base;

  // Rounding mode decode straight from the frm register. Encodings 5..7 are
  // reserved: every mode line drops and the illegal indicator is raised.
  always_comb begin
    rne        = 1'b0;
    rtz        = 1'b0;
    rdn        = 1'b0;
    rup        = 1'b0;
    rmm        = 1'b0;
    rm_illegal = 1'b0;
    case (frm)
      3'd0:    rne        = 1'b1;
      3'd1:    rtz        = 1'b1;
      3'd2:    rdn        = 1'b1;
      3'd3:    rup        = 1'b1;
      3'd4:    rmm        = 1'b1;
      default: rm_illegal = 1'b1;
    endcase
  end

  // Overflow always implies inexact, so NX is forced on whenever OF is set
  // before the flags are stored or accumulated.
  assign in_flags = {in_invalid, in_dz, in_overflow, in_underflow,
                     in_inexact | in_overflow};

  // Acceptance depends only on registered state (count and frm), so there is
  // no combinational path from out_ready back to in_ready.
  assign in_ready  = (count != 2'd2) & ~rm_illegal;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result = res_mem[rd_ptr];
  assign out_flags  = flg_mem[rd_ptr];

  // Two-entry circular buffer. Storage is cleared on reset so the head reads
  // as zero; a simultaneous push and pop leaves the occupancy unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        res_mem[i] <= '0;
        flg_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        res_mem[wr_ptr] <= in_result;
        flg_mem[wr_ptr] <= in_flags;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end
    end
  end

  // A software write to fflags replaces the base value, but flags of a result
  // accepted in the same cycle are still ORed in so none are ever lost.
  assign fflags_wr   = csr_we & ((csr_addr == 2'd0) | (csr_addr == 2'd2));
  assign fflags_base = fflags_wr ? csr_wdata[4:0] : fflags;

  // CSR state. Flags accumulate at acceptance time; an frm write only affects
  // results accepted after it lands, entries already buffered keep theirs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags <= 5'd0;
      frm    <= 3'd0;
    end else begin
      fflags <= fflags_base | (push ? in_flags : 5'd0);
      if (csr_we && csr_addr == 2'd1) begin
        frm <= csr_wdata[2:0];
      end else if (csr_we && csr_addr == 2'd2) begin
        frm <= csr_wdata[7:5];
      end
    end
  end

  // Combinational CSR read; the reserved address reads back as zero.
  always_comb begin
    csr_rdata = 8'd0;
    case (csr_addr)
      2'd0:    csr_rdata = {3'd0, fflags};
      2'd1:    csr_rdata = {5'd0, frm};
      2'd2:    csr_rdata = {frm, fflags};
      default: csr_rdata = 8'd0;
    endcase
  end

endmodule

// File: tb/tb_fp_wb_csr.sv
// ---------------------------------------------------------------------------
// tb_fp_wb_csr
// Self-checking bench for fp_wb_csr. Expected {result, flags} entries are
// queued as the bench sees them accepted and compared when they leave the
// buffer; each scenario task also checks handshake, CSR and mode behaviour.
// ---------------------------------------------------------------------------
module tb_fp_wb_csr;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_result;
  logic         in_invalid;
  logic         in_dz;
  logic         in_overflow;
  logic         in_underflow;
  logic         in_inexact;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [4:0]   out_flags;
  logic         csr_we;
  logic [1:0]   csr_addr;
  logic [7:0]   csr_wdata;
  logic [7:0]   csr_rdata;
  logic         rne;
  logic         rtz;
  logic         rdn;
  logic         rup;
  logic         rmm;
  logic         rm_illegal;

  int assertions = 0;
  int failures   = 0;
  logic [W+4:0] sb [$];

  fp_wb_csr #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_invalid(in_invalid), .in_dz(in_dz), .in_overflow(in_overflow),
    .in_underflow(in_underflow), .in_inexact(in_inexact),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .rne(rne), .rtz(rtz), .rdn(rdn), .rup(rup), .rmm(rmm),
    .rm_illegal(rm_illegal)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: at each falling edge, a pending pop is compared against the
  // oldest expected entry, then a pending push records its expected entry
  // with NX forced on by OF.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        assertions++;
        if (sb.size() == 0) begin
          failures++;
          $display("[TB] FAIL sb_unexpected: got %h/%b, expected nothing", out_result, out_flags);
        end else begin
          logic [W+4:0] exp_e;
          exp_e = sb.pop_front();
          if ({out_result, out_flags} !== exp_e) begin
            failures++;
            $display("[TB] FAIL sb_data: got %h/%b, expected %h/%b",
                     out_result, out_flags, exp_e[W+4:5], exp_e[4:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back({in_result, in_invalid, in_dz, in_overflow, in_underflow,
                      in_inexact | in_overflow});
      end
    end
  end

  // Sets the input-side signals; f is {NV,DZ,OF,UF,NX}.
  task automatic drive_in(input logic v, input logic [W-1:0] r, input logic [4:0] f);
    in_valid     = v;
    in_result    = r;
    in_invalid   = f[4];
    in_dz        = f[3];
    in_overflow  = f[2];
    in_underflow = f[1];
    in_inexact   = f[0];
  endtask

  // One-cycle CSR write; returns just after the edge that commits it.
  task automatic csr_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    csr_we    = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    @(posedge clk); #1;
    csr_we    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    assertions++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_hs: got valid=%b ready=%b, expected 0/1", out_valid, in_ready);
    end
    assertions++;
    if ({rne, rtz, rdn, rup, rmm, rm_illegal} !== 6'b100000) begin
      failures++;
      $display("[TB] FAIL reset_mode: got %b, expected 100000", {rne, rtz, rdn, rup, rmm, rm_illegal});
    end
    assertions++;
    if (out_result !== '0 || out_flags !== 5'd0 || csr_rdata !== 8'd0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h/%b/%h, expected zeros", out_result, out_flags, csr_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    drive_in(1'b1, 32'h3F800000, 5'b00000);
    @(negedge clk);
    assertions++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stream_n0: got valid=%b ready=%b, expected 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    drive_in(1'b1, 32'h40000000, 5'b00000);
    @(negedge clk);
    assertions++;
    if (out_valid !== 1'b1 || out_result !== 32'h3F800000) begin
      failures++;
      $display("[TB] FAIL stream_n1: got %b/%h, expected 1/3f800000", out_valid, out_result);
    end
    @(posedge clk); #1;
    drive_in(1'b1, 32'h7F800000, 5'b00100);
    @(negedge clk);
    assertions++;
    if (out_valid !== 1'b1 || out_result !== 32'h40000000) begin
      failures++;
      $display("[TB] FAIL stream_n2: got %b/%h, expected 1/40000000", out_valid, out_result);
    end
    @(posedge clk); #1;
    drive_in(1'b0, '0, 5'b00000);
    @(negedge clk);
    assertions++;
    if (out_result !== 32'h7F800000 || out_flags !== 5'b00101) begin
      failures++;
      $display("[TB] FAIL stream_n3: got %h/%b, expected 7f800000/00101", out_result, out_flags);
    end
    @(posedge clk); #1;
    csr_addr = 2'd0;
    #1;
    assertions++;
    if (csr_rdata !== 8'h05 || out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stream_fflags: got %h valid=%b, expected 05/0", csr_rdata, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive_in(1'b1, 32'h11111111, 5'b01000);
    @(negedge clk);
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_first: got ready=%b, expected 1", in_ready);
    end
    @(posedge clk); #1;
    drive_in(1'b1, 32'h22222222, 5'b00010);
    @(negedge clk);
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_second: got ready=%b, expected 1", in_ready);
    end
    @(posedge clk); #1;
    drive_in(1'b1, 32'h33333333, 5'b10000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      assertions++;
      if (in_ready !== 1'b0 || out_result !== 32'h11111111) begin
        failures++;
        $display("[TB] FAIL bp_full: got ready=%b head=%h, expected 0/11111111", in_ready, out_result);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    assertions++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_release0: got ready=%b, expected 0", in_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release1: got ready=%b, expected 1", in_ready);
    end
    @(posedge clk); #1;
    drive_in(1'b0, '0, 5'b00000);
    repeat (4) @(posedge clk);
    #1;
    assertions++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL bp_drain: got valid=%b pending=%0d, expected 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_mode_decode();
    logic [4:0] prev_mode;
    logic [4:0] exp_mode;
    prev_mode = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      exp_mode = 5'b10000 >> i;
      @(posedge clk); #1;
      csr_we    = 1'b1;
      csr_addr  = 2'd1;
      csr_wdata = 8'(i);
      @(negedge clk);
      assertions++;
      if ({rne, rtz, rdn, rup, rmm} !== prev_mode) begin
        failures++;
        $display("[TB] FAIL mode_early%0d: got %b, expected %b", i, {rne, rtz, rdn, rup, rmm}, prev_mode);
      end
      @(posedge clk); #1;
      csr_we = 1'b0;
      assertions++;
      if ({rne, rtz, rdn, rup, rmm, rm_illegal} !== {exp_mode, 1'b0} || csr_rdata !== 8'(i)) begin
        failures++;
        $display("[TB] FAIL mode_%0d: got %b rd=%h, expected %b0 rd=%h",
                 i, {rne, rtz, rdn, rup, rmm, rm_illegal}, csr_rdata, exp_mode, 8'(i));
      end
      prev_mode = exp_mode;
    end
  endtask

  task automatic test_illegal_mode();
    out_ready = 1'b1;
    csr_write(2'd1, 8'd5);
    assertions++;
    if ({rne, rtz, rdn, rup, rmm, rm_illegal} !== 6'b000001) begin
      failures++;
      $display("[TB] FAIL illegal_mode: got %b, expected 000001", {rne, rtz, rdn, rup, rmm, rm_illegal});
    end
    drive_in(1'b1, 32'h44444444, 5'b00001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      assertions++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL illegal_stall%0d: got ready=%b, expected 0", i, in_ready);
      end
      @(posedge clk); #1;
    end
    csr_write(2'd1, 8'd0);
    @(negedge clk);
    assertions++;
    if (in_ready !== 1'b1 || rne !== 1'b1) begin
      failures++;
      $display("[TB] FAIL illegal_resume: got ready=%b rne=%b, expected 1/1", in_ready, rne);
    end
    @(posedge clk); #1;
    drive_in(1'b0, '0, 5'b00000);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_collision();
    out_ready = 1'b1;
    csr_write(2'd0, 8'h10);
    csr_addr = 2'd0;
    #1;
    assertions++;
    if (csr_rdata !== 8'h10) begin
      failures++;
      $display("[TB] FAIL coll_pre: got %h, expected 10", csr_rdata);
    end
    @(posedge clk); #1;
    csr_we    = 1'b1;
    csr_addr  = 2'd0;
    csr_wdata = 8'h00;
    drive_in(1'b1, 32'h55555555, 5'b00011);
    @(negedge clk);
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL coll_ready: got %b, expected 1", in_ready);
    end
    @(posedge clk); #1;
    csr_we = 1'b0;
    drive_in(1'b0, '0, 5'b00000);
    csr_addr = 2'd0;
    #1;
    assertions++;
    if (csr_rdata !== 8'h03) begin
      failures++;
      $display("[TB] FAIL coll_fflags: got %h, expected 03", csr_rdata);
    end
    csr_addr = 2'd2;
    #1;
    assertions++;
    if (csr_rdata !== 8'h03) begin
      failures++;
      $display("[TB] FAIL coll_fcsr: got %h, expected 03", csr_rdata);
    end
    csr_addr = 2'd3;
    #1;
    assertions++;
    if (csr_rdata !== 8'h00) begin
      failures++;
      $display("[TB] FAIL coll_rsvd: got %h, expected 00", csr_rdata);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    csr_write(2'd1, 8'd3);
    drive_in(1'b1, 32'h66666666, 5'b00001);
    @(posedge clk); #1;
    drive_in(1'b1, 32'h77777777, 5'b01000);
    @(posedge clk); #1;
    drive_in(1'b0, '0, 5'b00000);
    csr_write(2'd0, 8'h1F);
    csr_addr = 2'd0;
    #1;
    assertions++;
    if (csr_rdata !== 8'h1F || out_valid !== 1'b1 || in_ready !== 1'b0 || rup !== 1'b1) begin
      failures++;
      $display("[TB] FAIL arst_pre: got ff=%h valid=%b ready=%b rup=%b, expected 1f/1/0/1",
               csr_rdata, out_valid, in_ready, rup);
    end
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    assertions++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || csr_rdata !== 8'h00) begin
      failures++;
      $display("[TB] FAIL arst_state: got valid=%b ready=%b ff=%h, expected 0/1/00",
               out_valid, in_ready, csr_rdata);
    end
    assertions++;
    if (rne !== 1'b1 || rm_illegal !== 1'b0 || out_result !== '0) begin
      failures++;
      $display("[TB] FAIL arst_mode: got rne=%b ill=%b res=%h, expected 1/0/0", rne, rm_illegal, out_result);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    assertions++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arst_after: got valid=%b, expected 0", out_valid);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    csr_we    = 1'b0;
    csr_addr  = 2'd0;
    csr_wdata = 8'd0;
    drive_in(1'b0, '0, 5'b00000);
    test_reset();
    test_stream();
    test_backpressure();
    test_mode_decode();
    test_illegal_mode();
    test_collision();
    test_async_reset();
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
